rsa_modexp_unit: RTL and testbench

//   Computes c = m^e mod p by Montgomery square-and-multiply, using one bit-serial Montgomery multiplier (MonPro).

---
 rtl/rsa_modexp_unit_if.sv | 27 ++
 rtl/rsa_modexp_unit.sv | 164 ++++++++++++++++
 tb/tb_rsa_modexp_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_unit_if.sv
// Operand, command and result bundle between the SPI register bank and the
// Montgomery modular exponentiation unit.
interface rsa_modexp_unit_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start_cmd;
  logic             stop_cmd;
  logic [WIDTH-1:0] rsa_p;
  logic [WIDTH-1:0] rsa_e;
  logic [WIDTH-1:0] rsa_m;
  logic [WIDTH-1:0] rsa_const;
  logic [WIDTH-1:0] rsa_c;
  logic             eoc;
  logic             busy;
  logic             err;

  modport master (
    output ena, start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const,
    input  rsa_c, eoc, busy, err
  );

  modport slave (
    input  ena, start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const,
    output rsa_c, eoc, busy, err
  );
endinterface

// File: rtl/rsa_modexp_unit.sv
// c = m^e mod p by left-to-right Montgomery square-and-multiply built around a
// single bit-serial MonPro datapath (WIDTH+1 cycles per product).
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rstb,
  rsa_modexp_unit_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = WIDTH + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE_M = 3'd1;
  localparam logic [2:0] S_PRE_X = 3'd2;
  localparam logic [2:0] S_SQR   = 3'd3;
  localparam logic [2:0] S_MUL   = 3'd4;
  localparam logic [2:0] S_POST  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_p, r_e, r_m, r_const;
  logic [WIDTH-1:0] r_mb, r_xb, r_res, r_c;
  logic [KW-1:0]    r_k;
  logic [CW-1:0]    r_cnt;
  logic [TW-1:0]    r_t;
  logic             r_eoc, r_err;

  logic [WIDTH-1:0] w_a, w_b, w_pp, w_res;
  logic [TW-1:0]    w_sum, w_odd;
  logic             w_abit, w_mp_done, w_stop;

  // MonPro operands follow directly from the state; they only change between products.
  always_comb begin
    w_a = r_xb;
    w_b = ONE;
    case (r_state)
      S_PRE_M: begin w_a = r_m;     w_b = r_const; end
      S_PRE_X: begin w_a = r_const; w_b = ONE;     end
      S_SQR:   begin w_a = r_xb;    w_b = r_xb;    end
      S_MUL:   begin w_a = r_mb;    w_b = r_xb;    end
      default: begin w_a = r_xb;    w_b = ONE;     end
    endcase
  end

  assign w_abit = w_a[r_cnt[KW-1:0]];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign w_pp[gi] = w_b[gi] & w_abit;
    end
  endgenerate

  // t stays below 2p, so t + B + p fits in WIDTH+2 bits.
  assign w_sum     = r_t + {2'b00, w_pp};
  assign w_odd     = w_sum[0] ? (w_sum + {2'b00, r_p}) : w_sum;
  assign w_res     = WIDTH'((r_t >= {2'b00, r_p}) ? (r_t - {2'b00, r_p}) : r_t);
  assign w_mp_done = (r_cnt == LAST);
  assign w_stop    = bus.stop_cmd && (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_e     <= '0;
      r_m     <= '0;
      r_const <= '0;
      r_mb    <= '0;
      r_xb    <= '0;
      r_res   <= '0;
      r_c     <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_t     <= '0;
      r_eoc   <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.ena) begin
      r_eoc <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
        r_t     <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start_cmd && !bus.stop_cmd) begin
              r_p     <= bus.rsa_p;
              r_e     <= bus.rsa_e;
              r_m     <= bus.rsa_m;
              r_const <= bus.rsa_const;
              r_err   <= ~bus.rsa_p[0];
              r_k     <= KW'(WIDTH - 1);
              r_t     <= '0;
              r_cnt   <= '0;
              if (!bus.rsa_p[0]) begin
                r_res   <= '0;
                r_state <= S_DONE;
              end else begin
                r_state <= S_PRE_M;
              end
            end
          end
          S_PRE_M, S_PRE_X, S_SQR, S_MUL, S_POST: begin
            if (!w_mp_done) begin
              r_t   <= w_odd >> 1;
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_t   <= '0;
              r_cnt <= '0;
              case (r_state)
                S_PRE_M: begin
                  r_mb    <= w_res;
                  r_state <= S_PRE_X;
                end
                S_PRE_X: begin
                  r_xb    <= w_res;
                  r_state <= S_SQR;
                end
                S_SQR: begin
                  r_xb <= w_res;
                  if (r_e[r_k]) begin
                    r_state <= S_MUL;
                  end else if (r_k == '0) begin
                    r_state <= S_POST;
                  end else begin
                    r_k <= r_k - KW'(1);
                  end
                end
                S_MUL: begin
                  r_xb <= w_res;
                  if (r_k == '0) begin
                    r_state <= S_POST;
                  end else begin
                    r_k     <= r_k - KW'(1);
                    r_state <= S_SQR;
                  end
                end
                default: begin
                  r_res   <= w_res;
                  r_state <= S_DONE;
                end
              endcase
            end
          end
          S_DONE: begin
            r_c     <= r_res;
            r_eoc   <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rsa_c = r_c;
  assign bus.eoc   = r_eoc;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.err   = r_err;
endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Bench for rsa_modexp_unit: fixed vectors, abort/freeze/reset sequences and
// randomized runs against a plain-arithmetic pow(m,e,p) model.
module tb_rsa_modexp_unit;
  localparam int W  = 8;
  localparam int L  = W + 1;
  localparam int NV = 8;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  rsa_modexp_unit_if #(.WIDTH(W)) bus_if ();
  rsa_modexp_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_if)
  );

  typedef struct {
    logic [7:0] p, e, m, k, c;
    logic       err;
    int         n;
  } vec_t;

  vec_t vt [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int modpow(input int m, input int e, input int p);
    int r = 1 % p;
    int b = m % p;
    for (int i = 0; i < W; i++) begin
      if (((e >> i) & 1) == 1) r = (r * b) % p;
      b = (b * b) % p;
    end
    return r;
  endfunction

  function automatic int model_lat(input int e, input int p);
    int pc = 0;
    if ((p % 2) == 0) return 1;
    for (int i = 0; i < W; i++) pc += (e >> i) & 1;
    return L * (3 + W + pc) + 1;
  endfunction

  // Start is sampled by the first edge; operand pins are scrambled afterwards.
  task automatic start_op(input logic [7:0] p, e, m, k);
    bus_if.rsa_p     = p;
    bus_if.rsa_e     = e;
    bus_if.rsa_m     = m;
    bus_if.rsa_const = k;
    bus_if.start_cmd = 1'b1;
    tick();
    bus_if.start_cmd = 1'b0;
    bus_if.rsa_p     = 8'($urandom);
    bus_if.rsa_e     = 8'($urandom);
    bus_if.rsa_m     = 8'($urandom);
    bus_if.rsa_const = 8'($urandom);
  endtask

  task automatic wait_eoc(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus_if.eoc === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int last_c;
    logic [7:0] rp, re, rm, rk;

    vt[0] = '{8'd13,  8'd5,    8'd7,   8'd3,  8'h0B, 1'b0, 118};
    vt[1] = '{8'd251, 8'hFA,   8'd2,   8'd25, 8'h01, 1'b0, 154};
    vt[2] = '{8'd251, 8'h00,   8'd2,   8'd25, 8'h01, 1'b0, 100};
    vt[3] = '{8'd12,  8'd5,    8'd7,   8'd0,  8'h00, 1'b1, 1};
    vt[4] = '{8'd13,  8'd5,    8'd7,   8'd3,  8'h0B, 1'b0, 118};
    vt[5] = '{8'd1,   8'd5,    8'd7,   8'd0,  8'h00, 1'b0, 118};
    vt[6] = '{8'd13,  8'd5,    8'd200, 8'd3,  8'h05, 1'b0, 118};
    vt[7] = '{8'd255, 8'hFF,   8'd2,   8'd1,  8'h80, 1'b0, 172};

    bus_if.ena       = 1'b1;
    bus_if.start_cmd = 1'b0;
    bus_if.stop_cmd  = 1'b0;
    bus_if.rsa_p     = '0;
    bus_if.rsa_e     = '0;
    bus_if.rsa_m     = '0;
    bus_if.rsa_const = '0;
    rstb = 1'b0;
    repeat (3) tick();
    chk("reset_rsa_c", int'(bus_if.rsa_c), 0);
    chk("reset_eoc",   int'(bus_if.eoc),   0);
    chk("reset_busy",  int'(bus_if.busy),  0);
    chk("reset_err",   int'(bus_if.err),   0);
    rstb = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      start_op(vt[i].p, vt[i].e, vt[i].m, vt[i].k);
      chk($sformatf("vec%0d_busy", i), int'(bus_if.busy), 1);
      wait_eoc(400, n);
      chk($sformatf("vec%0d_latency", i), n, vt[i].n);
      chk($sformatf("vec%0d_rsa_c", i), int'(bus_if.rsa_c), int'(vt[i].c));
      chk($sformatf("vec%0d_err", i), int'(bus_if.err), int'(vt[i].err));
      $display("vec%0d p=%0d e=%0d m=%0d -> c=%0d err=%0d n=%0d", i, vt[i].p, vt[i].e, vt[i].m,
               bus_if.rsa_c, bus_if.err, n);
      tick();
      chk($sformatf("vec%0d_eoc_pulse", i), int'(bus_if.eoc), 0);
    end
    last_c = int'(vt[NV-1].c);

    // Stray start at cycle 20 is ignored, stop at cycle 40 aborts.
    start_op(8'd13, 8'd5, 8'd7, 8'd3);
    repeat (19) tick();
    bus_if.start_cmd = 1'b1;
    bus_if.rsa_p     = 8'd12;
    tick();
    bus_if.start_cmd = 1'b0;
    repeat (19) tick();
    chk("abort_busy_before", int'(bus_if.busy), 1);
    chk("abort_err_before",  int'(bus_if.err),  0);
    bus_if.stop_cmd = 1'b1;
    tick();
    bus_if.stop_cmd = 1'b0;
    chk("abort_busy_after", int'(bus_if.busy), 0);
    wait_eoc(150, n);
    chk("abort_no_eoc", n, -1);
    chk("abort_rsa_c_kept", int'(bus_if.rsa_c), last_c);
    $display("abort run: busy=%0d rsa_c=%0d eoc_at=%0d", bus_if.busy, bus_if.rsa_c, n);

    // Ten frozen cycles mid-run shift eoc by ten.
    start_op(8'd13, 8'd5, 8'd7, 8'd3);
    repeat (29) tick();
    bus_if.ena = 1'b0;
    repeat (10) tick();
    bus_if.ena = 1'b1;
    wait_eoc(400, n);
    chk("freeze_latency", (n < 0) ? n : n + 39, 128);
    chk("freeze_rsa_c", int'(bus_if.rsa_c), 8'h0B);
    $display("freeze run: rsa_c=%0d eoc_at=%0d", bus_if.rsa_c, (n < 0) ? n : n + 39);
    bus_if.ena = 1'b0;
    repeat (3) tick();
    chk("eoc_stretched", int'(bus_if.eoc), 1);
    bus_if.ena = 1'b1;
    tick();
    chk("eoc_released", int'(bus_if.eoc), 0);

    // Reset at cycle 50 clears everything and suppresses eoc.
    start_op(8'd13, 8'd5, 8'd7, 8'd3);
    repeat (49) tick();
    rstb = 1'b0;
    tick();
    chk("midreset_rsa_c", int'(bus_if.rsa_c), 0);
    chk("midreset_eoc",   int'(bus_if.eoc),   0);
    chk("midreset_busy",  int'(bus_if.busy),  0);
    chk("midreset_err",   int'(bus_if.err),   0);
    rstb = 1'b1;
    wait_eoc(150, n);
    chk("midreset_no_eoc", n, -1);
    $display("reset run: rsa_c=%0d busy=%0d eoc_at=%0d", bus_if.rsa_c, bus_if.busy, n);

    for (int r = 0; r < 300; r++) begin
      rp = 8'(2 * $urandom_range(0, 127) + 1);
      re = 8'($urandom);
      rm = 8'($urandom);
      rk = 8'(65536 % int'(rp));
      start_op(rp, re, rm, rk);
      wait_eoc(400, n);
      chk($sformatf("rand%0d_latency", r), n, model_lat(int'(re), int'(rp)));
      chk($sformatf("rand%0d_rsa_c", r), int'(bus_if.rsa_c), modpow(int'(rm), int'(re), int'(rp)));
      chk($sformatf("rand%0d_err", r), int'(bus_if.err), 0);
      $display("rand%0d p=%0d e=%0d m=%0d -> c=%0d n=%0d", r, rp, re, rm, bus_if.rsa_c, n);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
